am_search_hf: RTL and testbench
===============================

Name: am_search_hf

Overview:
- Associative-memory search stage that consumes the bundled query hypervector produced by bundler_hf (its en/out + hv_out interface).
- Compares the query against NUM_CLASSES stored class prototypes, e.g. ictal and interictal, by Hamming distance. Reports the nearest class and its distance.
- Distance is computed chunk-serially, CHUNK bits per cycle, to bound popcount area at large DIMENSIONS.

Parameters:
- DIMENSIONS, 5, hypervector width in bits
- NUM_CLASSES, 2, number of class prototypes
- CHUNK, 2, bits XOR/popcounted per cycle (1 ≤ CHUNK ≤ DIMENSIONS)
- Derived NCHUNKS = ceil(DIMENSIONS/CHUNK), DW = $clog2(DIMENSIONS+1), CW = max(1,$clog2(NUM_CLASSES))

Ports:
- clk  input  1  rising-edge clock
- nrst  input  1  asynchronous active-low reset
- en  input  1  start pulse, qualifies hv_in (driven from bundler_hf out)
- hv_in  input  DIMENSIONS  query hypervector (from bundler_hf hv_out)
- class_hvs  input  [DIMENSIONS-1:0] x NUM_CLASSES unpacked array  prototypes; must be stable while busy
- busy  output  1  high while a search is in progress
- out  output  1  one-cycle result-valid pulse
- class_out  output  CW  index of nearest class
- dist_out  output  DW  Hamming distance of nearest class

Behaviour:
- Only clk and nrst are used: one clock, asynchronous active-low reset.
- Reset values: state=IDLE; busy, out, class_out, dist_out, and all internal counters and accumulators = 0.
- FSM states:
  - IDLE: on the rising edge with en=1, latch hv_in into a query register, clear class idx c=0, chunk idx k=0, acc=0, best_dist=all-ones saturate (DIMENSIONS+1 representable in DW+1 internal bits), best_idx=0. Go to SCAN. busy=1 from the next cycle.
  - SCAN: each cycle, acc += popcount(query[k-chunk] XOR class_hvs[c][k-chunk]). Bits at index ≥ DIMENSIONS in the last chunk are masked to 0.
    - k wraps 0..NCHUNKS-1.
    - On the last chunk of class c, the final sum acc_total is compared. If acc_total < best_dist (strict), update best_dist and best_idx. Then acc=0, k=0, c++.
    - After the last chunk of class NUM_CLASSES-1, go to DONE.
  - DONE: one cycle. out=1, class_out=best_idx (including any update from the final class), dist_out=best_dist[DW-1:0], busy=0 on exit. Return to IDLE.
- Latency: en sampled at edge E0 → SCAN occupies NUM_CLASSES*NCHUNKS cycles → out high in the cycle following edge E0+NUM_CLASSES*NCHUNKS+1. With defaults this is 7 cycles.
- class_out and dist_out hold their values after the out pulse until the next DONE. out is a strict single-cycle pulse.
- Ties: the lowest class index wins, because the update is strict less-than.
- en while busy (SCAN or DONE) is ignored and not queued. en in the same cycle DONE returns to IDLE is also ignored; a new start needs en in IDLE.
- hv_in changes after the start edge do not affect the result, because it is latched. class_hvs changes during SCAN are undefined usage.
- Reset asserted mid-SCAN or mid-DONE: immediate return to IDLE, all outputs 0, no out pulse.
- The accumulator never overflows: the maximum is DIMENSIONS, which fits in DW bits.

Test Plan:
- Basic, default parameters: hv_in=5'b01111, class0=5'b01101, class1=5'b10000, en 1 cycle → out pulses exactly 7 cycles after the en edge, class_out=0, dist_out=1. busy is high for 6 cycles.
- Tie: hv_in=5'b00000, class0=5'b00011, class1=5'b10100 → class_out=0, dist_out=2.
- Last-chunk masking and the final-class update: hv_in=5'b11111, class0=5'b00000, class1=5'b11111 → class_out=1, dist_out=0. Repeat with CHUNK=3 and CHUNK=5; the result is identical and the latency is 2*NCHUNKS+1.
- Busy ignore: start the search with hv_in=5'b01111, then pulse en with hv_in=5'b10000 two cycles later → a single out pulse, result class 0 / dist 1. Outputs hold afterwards and no second pulse appears.
- Reset mid-search: drop nrst asynchronously, off-edge, during SCAN → busy, out, class_out and dist_out are 0 immediately. After release, a fresh en yields a correct result.
- Back-to-back: chain from a bundler_hf-style driver with en pulses 10 cycles apart and 3 distinct queries → 3 out pulses, each matching a reference model of min-Hamming distance with lowest-index tie-break.

Source files
------------

// File: rtl/am_search_hf_if.sv
// Query/result handshake between a bundler_hf-style producer and am_search_hf.
interface am_search_hf_if #(
    parameter int DIMENSIONS  = 5,
    parameter int NUM_CLASSES = 2
);
    localparam int DW = $clog2(DIMENSIONS + 1);
    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    logic                  en;
    logic [DIMENSIONS-1:0] hv_in;
    logic                  busy;
    logic                  out;
    logic [CW-1:0]         class_out;
    logic [DW-1:0]         dist_out;

    modport master (
        output en, hv_in,
        input  busy, out, class_out, dist_out
    );

    modport slave (
        input  en, hv_in,
        output busy, out, class_out, dist_out
    );
endinterface

// File: rtl/am_search_hf.sv
// Associative-memory search: nearest class prototype by Hamming distance,
// accumulated CHUNK bits per cycle over every class in turn.
//
// state | meaning
// IDLE  | waiting for en; latches the query and clears the search state
// SCAN  | one chunk of one class per cycle; best result updated on each class's last chunk
// DONE  | single cycle; publishes best class/distance with a one-cycle out pulse
module am_search_hf #(
    parameter int DIMENSIONS  = 5,
    parameter int NUM_CLASSES = 2,
    parameter int CHUNK       = 2
) (
    input logic                  clk,
    input logic                  nrst,
    am_search_hf_if.slave        bus,
    input logic [DIMENSIONS-1:0] class_hvs [NUM_CLASSES]
);
    localparam int NCHUNKS = (DIMENSIONS + CHUNK - 1) / CHUNK;
    localparam int DW      = $clog2(DIMENSIONS + 1);
    localparam int CW      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int KW      = (NCHUNKS > 1) ? $clog2(NCHUNKS) : 1;
    localparam int PW      = NCHUNKS * CHUNK;
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNKS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DIMENSIONS-1:0] query;
    logic [CW-1:0]         c;
    logic [KW-1:0]         k;
    logic [DW-1:0]         acc;
    logic [DW:0]           best_dist;
    logic [CW-1:0]         best_idx;

    logic [PW-1:0]         diff_pad;
    logic [CHUNK-1:0]      diff_chunk;
    logic [DW-1:0]         pop;
    logic [DW-1:0]         acc_total;
    logic                  last_chunk;
    logic                  last_class;
    logic                  better;

    // Zero-extending to a whole number of chunks masks the tail of the last chunk.
    always_comb begin
        diff_pad   = PW'(query ^ class_hvs[c]);
        diff_chunk = CHUNK'(diff_pad >> (k * CHUNK));
        pop        = '0;
        for (int i = 0; i < CHUNK; i++) begin
            pop = pop + DW'(diff_chunk[i]);
        end
        acc_total  = acc + pop;
        better     = ({1'b0, acc_total} < best_dist);
        last_chunk = (k == K_LAST);
        last_class = (c == C_LAST);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en) state_nxt = SCAN;
            SCAN:    if (last_chunk && last_class) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            query         <= '0;
            c             <= '0;
            k             <= '0;
            acc           <= '0;
            best_dist     <= '0;
            best_idx      <= '0;
            bus.busy      <= 1'b0;
            bus.out       <= 1'b0;
            bus.class_out <= '0;
            bus.dist_out  <= '0;
        end else begin
            bus.out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        query     <= bus.hv_in;
                        c         <= '0;
                        k         <= '0;
                        acc       <= '0;
                        best_dist <= '1;
                        best_idx  <= '0;
                        bus.busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (last_chunk) begin
                        // Strict compare: on a tie the earlier class is kept.
                        if (better) begin
                            best_dist <= {1'b0, acc_total};
                            best_idx  <= c;
                        end
                        acc <= '0;
                        k   <= '0;
                        if (last_class) begin
                            bus.busy <= 1'b0;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end else begin
                        acc <= acc_total;
                        k   <= k + 1'b1;
                    end
                end
                DONE: begin
                    bus.out       <= 1'b1;
                    bus.class_out <= best_idx;
                    bus.dist_out  <= best_dist[DW-1:0];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_am_search_hf.sv
// Scoreboard bench for am_search_hf: three instances (CHUNK 2, 3, 5) share one
// stimulus stream and are checked against a min-Hamming reference model.
module tb_am_search_hf;
    localparam int D    = 5;
    localparam int NC   = 2;
    localparam int DW   = $clog2(D + 1);
    localparam int CW   = 1;
    localparam int NDUT = 3;

    typedef struct packed {
        int cls;
        int dst;
        int due;
    } exp_t;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic [D-1:0]  hv_in;
    logic [D-1:0]  class_hvs [NC];

    logic [NDUT-1:0] out_v;
    logic [NDUT-1:0] busy_v;
    logic [CW-1:0]   cls_v [NDUT];
    logic [DW-1:0]   dst_v [NDUT];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t exp_q [NDUT][$];
    int   e_prev  [NDUT];
    int   busy_lo [NDUT];
    int   busy_hi [NDUT];
    int   last_cls [NDUT];
    int   last_dst [NDUT];

    function automatic int chunk_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 3 : 5);
    endfunction

    function automatic int scan_len(input int g);
        return NC * ((D + chunk_of(g) - 1) / chunk_of(g));
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int CH = (g == 0) ? 2 : ((g == 1) ? 3 : 5);
        am_search_hf_if #(.DIMENSIONS(D), .NUM_CLASSES(NC)) bus ();
        assign bus.en    = en;
        assign bus.hv_in = hv_in;
        am_search_hf #(.DIMENSIONS(D), .NUM_CLASSES(NC), .CHUNK(CH)) dut (
            .clk       (clk),
            .nrst      (nrst),
            .bus       (bus),
            .class_hvs (class_hvs)
        );
        assign out_v[g]  = bus.out;
        assign busy_v[g] = bus.busy;
        assign cls_v[g]  = bus.class_out;
        assign dst_v[g]  = bus.dist_out;
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void ref_search(input logic [D-1:0] q, output int cls, output int dst);
        dst = D + 1;
        cls = 0;
        for (int i = 0; i < NC; i++) begin
            int d;
            d = $countones(q ^ class_hvs[i]);
            if (d < dst) begin
                dst = d;
                cls = i;
            end
        end
    endfunction

    function automatic void chk(input string name, input int g, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s dut%0d (chunk %0d) cycle %0d: got %0d, expected %0d",
                     name, g, chunk_of(g), cyc, act, req);
        end
    endfunction

    // Monitor: every cycle, compare each instance against the scoreboard.
    always @(negedge clk) begin
        exp_t x;
        for (int g = 0; g < NDUT; g++) begin
            if (!nrst) begin
                exp_q[g].delete();
                last_cls[g] = 0;
                last_dst[g] = 0;
                chk("rst_busy",  g, int'(busy_v[g]), 0);
                chk("rst_out",   g, int'(out_v[g]), 0);
                chk("rst_class", g, int'(cls_v[g]), 0);
                chk("rst_dist",  g, int'(dst_v[g]), 0);
            end else begin
                chk("busy", g, int'(busy_v[g]), int'(cyc >= busy_lo[g] && cyc <= busy_hi[g]));
                if (exp_q[g].size() > 0 && exp_q[g][0].due == cyc) begin
                    x = exp_q[g].pop_front();
                    chk("out_pulse", g, int'(out_v[g]), 1);
                    last_cls[g] = x.cls;
                    last_dst[g] = x.dst;
                end else begin
                    chk("out_quiet", g, int'(out_v[g]), 0);
                end
                chk("class_out", g, int'(cls_v[g]), last_cls[g]);
                chk("dist_out",  g, int'(dst_v[g]), last_dst[g]);
            end
        end
    end

    task automatic model_reset();
        for (int g = 0; g < NDUT; g++) begin
            e_prev[g]  = -1000;
            busy_lo[g] = 1;
            busy_hi[g] = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_classes(input logic [D-1:0] c0, input logic [D-1:0] c1);
        class_hvs[0] = c0;
        class_hvs[1] = c1;
    endtask

    // Pulse en for one edge; instances that are idle at that edge accept it.
    task automatic start(input logic [D-1:0] q);
        int   e;
        int   cls;
        int   dst;
        exp_t x;
        en    = 1'b1;
        hv_in = q;
        @(posedge clk);
        #1;
        e     = cyc;
        en    = 1'b0;
        hv_in = D'($urandom);
        ref_search(q, cls, dst);
        for (int g = 0; g < NDUT; g++) begin
            if (e >= e_prev[g] + scan_len(g) + 2) begin
                x.cls = cls;
                x.dst = dst;
                x.due = e + scan_len(g) + 1;
                exp_q[g].push_back(x);
                e_prev[g]  = e;
                busy_lo[g] = e;
                busy_hi[g] = e + scan_len(g) - 1;
            end
        end
    endtask

    initial begin
        nrst  = 1'b0;
        en    = 1'b0;
        hv_in = '0;
        set_classes('0, '0);
        model_reset();
        repeat (3) @(posedge clk);
        #3 nrst = 1'b1;
        idle(1);

        set_classes(5'b01101, 5'b10000);
        start(5'b01111);
        idle(10);

        set_classes(5'b00011, 5'b10100);
        start(5'b00000);
        idle(10);

        set_classes(5'b00000, 5'b11111);
        start(5'b11111);
        idle(10);

        set_classes(5'b01101, 5'b10000);
        start(5'b01111);
        idle(1);
        start(5'b10000);
        idle(12);

        // Asynchronous reset between clock edges while scanning.
        set_classes(5'b10101, 5'b01010);
        start(5'b11100);
        idle(2);
        #3 nrst = 1'b0;
        model_reset();
        idle(2);
        #3 nrst = 1'b1;
        idle(1);
        start(5'b11100);
        idle(10);

        // Back-to-back queries, en 10 cycles apart.
        set_classes(5'b11001, 5'b00110);
        start(5'b11000);
        idle(9);
        start(5'b00111);
        idle(9);
        start(5'b10110);
        idle(10);

        // Random queries and gaps; prototypes change only when no instance is scanning.
        for (int it = 0; it < 40; it++) begin
            bit safe;
            safe = 1'b1;
            for (int g = 0; g < NDUT; g++) begin
                if (cyc < e_prev[g] + scan_len(g)) safe = 1'b0;
            end
            if (safe && ($urandom_range(0, 1) == 1)) begin
                set_classes(D'($urandom), D'($urandom));
            end
            start(D'($urandom));
            idle($urandom_range(0, 9));
        end
        idle(15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
